// File: rtl/switch_box_cfgchain_if.sv
// Configuration chain bundle between the fabric config controller (master) and a switch box (slave).
// cfg_capture exists only when SWITCH_BOX_CFG_READBACK_EN is defined.
interface switch_box_cfgchain_if;
  logic cfg_in;
  logic cfg_shift;
  logic cfg_commit;
  logic cfg_out;
  logic cfg_full;
  logic cfg_done;
  logic cfg_error;
`ifdef SWITCH_BOX_CFG_READBACK_EN
  logic cfg_capture;

  modport master (
    output cfg_in, cfg_shift, cfg_commit, cfg_capture,
    input  cfg_out, cfg_full, cfg_done, cfg_error
  );
  modport slave (
    input  cfg_in, cfg_shift, cfg_commit, cfg_capture,
    output cfg_out, cfg_full, cfg_done, cfg_error
  );
`else
  modport master (
    output cfg_in, cfg_shift, cfg_commit,
    input  cfg_out, cfg_full, cfg_done, cfg_error
  );
  modport slave (
    input  cfg_in, cfg_shift, cfg_commit,
    output cfg_out, cfg_full, cfg_done, cfg_error
  );
`endif
endinterface

// File: rtl/switch_box_cfgchain.sv
// Fabric switch box: per-side track muxes and LE input muxes driven by a double-buffered config
// loaded through a serial daisy chain. Define SWITCH_BOX_CFG_READBACK_EN to add active-config readback.
module switch_box_cfgchain #(
  parameter int IC_PAIRS = 10,
  parameter int CLUSTER  = 4,
  parameter int LUT_SIZE = 6,
  parameter int OUT_REG  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [IC_PAIRS-1:0]         data_north_in,
  input  logic [IC_PAIRS-1:0]         data_east_in,
  input  logic [IC_PAIRS-1:0]         data_south_in,
  input  logic [IC_PAIRS-1:0]         data_west_in,
  output logic [IC_PAIRS-1:0]         data_north_out,
  output logic [IC_PAIRS-1:0]         data_east_out,
  output logic [IC_PAIRS-1:0]         data_south_out,
  output logic [IC_PAIRS-1:0]         data_west_out,
  input  logic [CLUSTER-1:0]          data_from_les,
  output logic [CLUSTER*LUT_SIZE-1:0] data_to_les,
  switch_box_cfgchain_if.slave        cfg
);
  localparam int SIDE_SW   = $clog2(3 + CLUSTER);
  localparam int SIDE_CW   = SIDE_SW + 1;
  localparam int LE_SW     = $clog2(4 * IC_PAIRS + CLUSTER);
  localparam int LE_CW     = LE_SW + 1;
  localparam int NUM_LE_IN = CLUSTER * LUT_SIZE;
  localparam int CONF_BITS = 4 * IC_PAIRS * SIDE_CW + NUM_LE_IN * LE_CW;
  localparam int LE_BASE   = 4 * IC_PAIRS * SIDE_CW;
  localparam int SIDE_SRC  = CLUSTER + 3;
  localparam int LE_SRC    = 4 * IC_PAIRS + CLUSTER;
  localparam int CNT_W     = $clog2(CONF_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CONF_BITS);

  typedef enum logic [1:0] {EMPTY, LOADING, FULL} cfg_state_t;

  logic [CONF_BITS-1:0] shadow_reg;
  logic [CONF_BITS-1:0] active_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CNT_W-1:0]     cnt_next;
  cfg_state_t           state_reg;
  logic                 done_reg;
  logic                 error_reg;
  logic                 capture;
  logic                 commit_ok;

`ifdef SWITCH_BOX_CFG_READBACK_EN
  assign capture = cfg.cfg_capture;
`else
  assign capture = 1'b0;
`endif

  // A capture in the same cycle swallows the commit without flagging an error.
  assign commit_ok = cfg.cfg_commit && !capture && (state_reg == FULL);

  always_comb begin
    cnt_next = cnt_reg;
    if (capture)
      cnt_next = CNT_FULL;
    else if (commit_ok)
      cnt_next = cfg.cfg_shift ? CNT_W'(1) : '0;
    else if (cfg.cfg_shift && (state_reg != FULL))
      cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= '0;
      active_reg <= '0;
      cnt_reg    <= '0;
      state_reg  <= EMPTY;
      done_reg   <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (cnt_next == CNT_FULL)
        state_reg <= FULL;
      else if (cnt_next == '0)
        state_reg <= EMPTY;
      else
        state_reg <= LOADING;

      if (capture)
        shadow_reg <= active_reg;
      else if (cfg.cfg_shift)
        shadow_reg <= {shadow_reg[CONF_BITS-2:0], cfg.cfg_in};

      if (commit_ok) begin
        active_reg <= shadow_reg;
        done_reg   <= 1'b1;
      end
      if (cfg.cfg_commit && !capture && (state_reg != FULL))
        error_reg <= 1'b1;
    end
  end

  assign cfg.cfg_out   = shadow_reg[CONF_BITS-1];
  assign cfg.cfg_full  = (state_reg == FULL);
  assign cfg.cfg_done  = done_reg;
  assign cfg.cfg_error = error_reg;

  function automatic logic side_pick(input logic [SIDE_CW-1:0] word,
                                     input logic [SIDE_SRC-1:0] src);
    logic [SIDE_SW-1:0] sel;
    sel = word[SIDE_SW-1:0];
    side_pick = 1'b0;
    if (word[SIDE_CW-1] && (32'(sel) < SIDE_SRC))
      side_pick = src[sel];
  endfunction

  function automatic logic le_pick(input logic [LE_CW-1:0] word,
                                   input logic [LE_SRC-1:0] src);
    logic [LE_SW-1:0] sel;
    sel = word[LE_SW-1:0];
    le_pick = 1'b0;
    if (word[LE_CW-1] && (32'(sel) < LE_SRC))
      le_pick = src[sel];
  endfunction

  logic [IC_PAIRS-1:0]  route_n, route_e, route_s, route_w;
  logic [NUM_LE_IN-1:0] route_le;
  logic [LE_SRC-1:0]    le_src;

  // Source vectors are {turn B, straight, turn A, LE outputs} so select CLUSTER lands on turn A.
  for (genvar gi = 0; gi < IC_PAIRS; gi++) begin : g_track
    localparam int NXT = (gi + 1) % IC_PAIRS;
    localparam int MIR = (IC_PAIRS - gi) % IC_PAIRS;
    localparam int REV = (2 * IC_PAIRS - 2 - gi) % IC_PAIRS;

    assign route_n[gi] = side_pick(active_reg[(0 * IC_PAIRS + gi) * SIDE_CW +: SIDE_CW],
      {data_east_in[MIR], data_south_in[gi], data_west_in[NXT], data_from_les});
    assign route_e[gi] = side_pick(active_reg[(1 * IC_PAIRS + gi) * SIDE_CW +: SIDE_CW],
      {data_north_in[MIR], data_west_in[gi], data_south_in[NXT], data_from_les});
    assign route_s[gi] = side_pick(active_reg[(2 * IC_PAIRS + gi) * SIDE_CW +: SIDE_CW],
      {data_east_in[NXT], data_north_in[gi], data_west_in[REV], data_from_les});
    assign route_w[gi] = side_pick(active_reg[(3 * IC_PAIRS + gi) * SIDE_CW +: SIDE_CW],
      {data_south_in[REV], data_east_in[gi], data_north_in[NXT], data_from_les});
  end

  assign le_src = {data_north_in, data_east_in, data_south_in, data_west_in, data_from_les};

  for (genvar gi = 0; gi < NUM_LE_IN; gi++) begin : g_le
    assign route_le[gi] = le_pick(active_reg[LE_BASE + gi * LE_CW +: LE_CW], le_src);
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [IC_PAIRS-1:0]  north_reg, east_reg, south_reg, west_reg;
    logic [NUM_LE_IN-1:0] le_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        north_reg <= '0;
        east_reg  <= '0;
        south_reg <= '0;
        west_reg  <= '0;
        le_reg    <= '0;
      end else begin
        north_reg <= route_n;
        east_reg  <= route_e;
        south_reg <= route_s;
        west_reg  <= route_w;
        le_reg    <= route_le;
      end
    end

    assign data_north_out = north_reg;
    assign data_east_out  = east_reg;
    assign data_south_out = south_reg;
    assign data_west_out  = west_reg;
    assign data_to_les    = le_reg;
  end else begin : g_out_comb
    assign data_north_out = route_n;
    assign data_east_out  = route_e;
    assign data_south_out = route_s;
    assign data_west_out  = route_w;
    assign data_to_les    = route_le;
  end
endmodule

// File: tb/tb_switch_box_cfgchain.sv
// Directed bench for switch_box_cfgchain at default parameters: reset, routing, frame checks, chain, readback.
`timescale 1ns/1ps
module tb_switch_box_cfgchain;
  localparam int W       = 10;
  localparam int CL      = 4;
  localparam int LS      = 6;
  localparam int OUT_REG = 0;
  localparam int NB      = 328;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]     n_in, e_in, s_in, w_in;
  logic [W-1:0]     n_out, e_out, s_out, w_out;
  logic [CL-1:0]    les_in;
  logic [CL*LS-1:0] les_out;

  switch_box_cfgchain_if cfg_bus();

  switch_box_cfgchain #(.IC_PAIRS(W), .CLUSTER(CL), .LUT_SIZE(LS), .OUT_REG(OUT_REG)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_north_in  (n_in),
    .data_east_in   (e_in),
    .data_south_in  (s_in),
    .data_west_in   (w_in),
    .data_north_out (n_out),
    .data_east_out  (e_out),
    .data_south_out (s_out),
    .data_west_out  (w_out),
    .data_from_les  (les_in),
    .data_to_les    (les_out),
    .cfg            (cfg_bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic set_ins(input logic [W-1:0] n, input logic [W-1:0] e, input logic [W-1:0] s,
                         input logic [W-1:0] w, input logic [CL-1:0] l);
    n_in = n; e_in = e; s_in = s; w_in = w; les_in = l;
    #1;
    if (OUT_REG != 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic shift_bits(input logic [NB-1:0] fr, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      @(negedge clk);
      cfg_bus.cfg_in    = fr[i];
      cfg_bus.cfg_shift = 1'b1;
    end
    @(negedge clk);
    cfg_bus.cfg_shift = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk);
    cfg_bus.cfg_commit = 1'b1;
    @(negedge clk);
    cfg_bus.cfg_commit = 1'b0;
  endtask

  logic [NB-1:0]   fa, fb, ft, zero;
  logic [NB+7:0]   seq;
  logic [W-1:0]    ones;

  initial begin
    ones = '1;
    zero = '0;
    fa = '0;
    fa[3:0]     = 4'hD;   // north[0] straight from south[0]
    fa[51:48]   = 4'hC;   // east[2] turn A from south[3]
    fa[123:120] = 4'hF;   // west[0] enabled, out-of-range select
    fa[166:160] = 7'h42;  // LE 0 input 0 from LE output 2
    fb = '0;
    fb[215:209] = 7'h44;  // LE 1 input 1 from west[0]
    ft = '0;
    ft[3:0]     = 4'hD;
    seq = {8'hA5, ft};

    cfg_bus.cfg_in = 1'b0;
    cfg_bus.cfg_shift = 1'b0;
    cfg_bus.cfg_commit = 1'b0;
`ifdef SWITCH_BOX_CFG_READBACK_EN
    cfg_bus.cfg_capture = 1'b0;
`endif
    n_in = '1; e_in = '1; s_in = '1; w_in = '1; les_in = '1;

    #23;
    check("rst_full",  cfg_bus.cfg_full, 0);
    check("rst_done",  cfg_bus.cfg_done, 0);
    check("rst_error", cfg_bus.cfg_error, 0);
    check("rst_cfgout", cfg_bus.cfg_out, 0);
    check("rst_route", {n_out, e_out, s_out, w_out, les_out}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_ins(W'($urandom), W'($urandom), W'($urandom), W'($urandom), CL'($urandom));
      check("idle_route", {n_out, e_out, s_out, w_out, les_out}, 64'h0);
    end

    // Frame A: straight, turn, invalid select and LE-to-LE routes.
    shift_bits(fa, NB-1, 0);
    check("a_full", cfg_bus.cfg_full, 1);
    commit();
    check("a_done", cfg_bus.cfg_done, 1);
    check("a_full_clr", cfg_bus.cfg_full, 0);
    check("a_error", cfg_bus.cfg_error, 0);
    set_ins('0, '0, 10'h001, '0, '0);
    check("a_straight", {n_out, e_out, s_out, w_out, les_out}, {10'h001, 10'h000, 10'h000, 10'h000, 24'h0});
    set_ins('0, '0, 10'h008, '0, '0);
    check("a_turn", {n_out, e_out, s_out, w_out, les_out}, {10'h000, 10'h004, 10'h000, 10'h000, 24'h0});
    set_ins(ones, ones, ones, ones, 4'h4);
    check("a_all", {n_out, e_out, s_out, w_out, les_out}, {10'h001, 10'h004, 10'h000, 10'h000, 24'h000001});
    set_ins(ones, ones, ones, ones, 4'hB);
    check("a_le_off", {n_out, e_out, s_out, w_out, les_out}, {10'h001, 10'h004, 10'h000, 10'h000, 24'h0});

    // Frame B: LE 1 input 1 from west[0].
    shift_bits(fb, NB-1, 0);
    commit();
    set_ins(ones, ones, ones, 10'h3FE, '1);
    check("b_le_lo", {n_out, e_out, s_out, w_out, les_out}, 64'h0);
    set_ins('0, '0, '0, 10'h001, '0);
    check("b_le_hi", {n_out, e_out, s_out, w_out, les_out}, {40'h0, 24'h000080});

    // Short frame: 100 bits then a rejected commit, then the remaining 228 bits.
    shift_bits(fa, NB-1, 228);
    check("short_full", cfg_bus.cfg_full, 0);
    commit();
    check("short_error", cfg_bus.cfg_error, 1);
    check("short_full2", cfg_bus.cfg_full, 0);
    set_ins('0, '0, 10'h001, 10'h001, '0);
    check("short_active", {n_out, e_out, s_out, w_out, les_out}, {40'h0, 24'h000080});
    shift_bits(fa, 227, 0);
    check("rest_full", cfg_bus.cfg_full, 1);
    commit();
    check("rest_done", cfg_bus.cfg_done, 1);
    check("rest_error", cfg_bus.cfg_error, 1);
    set_ins('0, '0, 10'h001, 10'h001, '0);
    check("rest_route", {n_out, e_out, s_out, w_out, les_out}, {10'h001, 40'h0, 14'h0});

    // Chain: 336 shifts, first 8 bits reappear on cfg_out after 328 shifts.
    for (int k = 1; k <= NB + 8; k++) begin
      @(negedge clk);
      cfg_bus.cfg_in    = seq[NB+8-k];
      cfg_bus.cfg_shift = 1'b1;
      @(posedge clk);
      #1;
      if (k == NB - 1) check("chain_full_lo", cfg_bus.cfg_full, 0);
      if (k >= NB) check("chain_out", cfg_bus.cfg_out, seq[NB+7-(k-NB)]);
    end
    @(negedge clk);
    cfg_bus.cfg_in     = 1'b1;
    cfg_bus.cfg_shift  = 1'b1;
    cfg_bus.cfg_commit = 1'b1;
    @(negedge clk);
    cfg_bus.cfg_shift  = 1'b0;
    cfg_bus.cfg_commit = 1'b0;
    check("sim_full", cfg_bus.cfg_full, 0);
    set_ins('0, '0, ones, '0, '0);
    check("sim_preshift", {n_out, e_out, s_out, w_out, les_out}, {10'h001, 54'h0});
    shift_bits(zero, 325, 0);
    check("sim_cnt327", cfg_bus.cfg_full, 0);
    shift_bits(zero, 0, 0);
    check("sim_cnt328", cfg_bus.cfg_full, 1);

`ifdef SWITCH_BOX_CFG_READBACK_EN
    shift_bits(fa, NB-1, 0);
    commit();
    set_ins('0, '0, 10'h001, '0, '0);
    check("rb_route_pre", n_out, 10'h001);
    @(negedge clk);
    cfg_bus.cfg_capture = 1'b1;
    @(negedge clk);
    cfg_bus.cfg_capture = 1'b0;
    check("rb_full", cfg_bus.cfg_full, 1);
    for (int m = 0; m < NB; m++) begin
      check("rb_out", cfg_bus.cfg_out, fa[NB-1-m]);
      cfg_bus.cfg_in    = 1'b0;
      cfg_bus.cfg_shift = 1'b1;
      @(negedge clk);
    end
    cfg_bus.cfg_shift = 1'b0;
    set_ins('0, '0, 10'h001, '0, '0);
    check("rb_route_post", n_out, 10'h001);
    shift_bits(fa, NB-1, 0);
`endif

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    cfg_bus.cfg_in    = 1'b1;
    cfg_bus.cfg_shift = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_full",  cfg_bus.cfg_full, 0);
    check("arst_done",  cfg_bus.cfg_done, 0);
    check("arst_error", cfg_bus.cfg_error, 0);
    check("arst_cfgout", cfg_bus.cfg_out, 0);
    check("arst_route", {n_out, e_out, s_out, w_out, les_out}, 64'h0);
    cfg_bus.cfg_shift = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_ins(W'($urandom), W'($urandom), W'($urandom), W'($urandom), CL'($urandom));
      check("post_rst_route", {n_out, e_out, s_out, w_out, les_out}, 64'h0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
